bit_packer: RTL and testbench
=============================

# bit_packer

Receiving end of the set-bit interface (`enable`/`val`/`size_of_bit`/`flush`) driven by the header generator and the slice coders. Appends the low `size_of_bit` bits of `val`, MSB first, to a continuous bitstream. Emits the stream as 64-bit big-endian words to the output buffer writer and maintains the running byte count that feeds back as `set_bit_total_byte_size`.

## Interface
- `BYTE_COUNT_WIDTH`, default 32: width of `total_byte_size`.
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  append request this cycle.
- `val`  in  64  source bits, right-aligned; bits at and above `size_of_bit` ignored.
- `size_of_bit`  in  64  number of bits to append. 0 is a no-op; 1..64 legal; >64 is an error.
- `flush`  in  1  pad the stream to a byte boundary and emit all pending bytes.
- `out_valid`  out  1  `out_data` holds a word this cycle.
- `out_data`  out  64  stream bytes, first byte in [63:56]; unused low bytes are zero.
- `out_num_bytes`  out  4  valid bytes in `out_data`, 1..8; 0 when `out_valid`=0.
- `total_byte_size`  out  BYTE_COUNT_WIDTH  bytes emitted since reset, including the current `out_valid` word.
- `fill_bits`  out  7  bits currently held and not yet emitted, 0..127 (debug).
- `size_err`  out  1  one-cycle pulse for `enable` with `size_of_bit`>64.

## Operation
- 128-bit accumulator `acc`, bits packed from [127] downward; fill count `fill` 0..128.
- State machine RUN/DRAIN; reset enters RUN.
- Append, when `enable` and 1≤n≤64: `acc` gets `val[n-1:0]` at positions `[127-fill : 128-fill-n]` and `fill += n`.
- Error, when `enable` and n>64: no append; `size_err`=1 next cycle; `flush` is still honoured.
- RUN, no flush: if post-append fill ≥64, emit `acc[127:64]` with 8 bytes, shift `acc` left 64, and `fill -= 64`.
- RUN, with flush: the append occurs first, then fill is rounded up to a multiple of 8 with zero padding. Then:
  - padded fill 0: nothing emitted.
  - 1..64: emit `ceil(fill/8)` bytes; fill becomes 0.
  - >64: emit 8 bytes, keep the remaining byte-aligned bits, and enter DRAIN.
- DRAIN:
  - Emit the residual as a partial word with residual/8 bytes (1..8).
  - Same-cycle input is appended behind the residual, so no bits are lost.
  - If `flush` is also asserted and new bits are present, stay in DRAIN so they are padded and emitted next cycle; otherwise return to RUN.
- `total_byte_size` increments by `out_num_bytes` on each emitted word and wraps modulo 2^BYTE_COUNT_WIDTH.
- Bits of `val` above n never affect the output.

## Timing
- All outputs registered. Latency: the word completed by an input in cycle T appears with `out_valid` in T+1.
- Throughput: one input per cycle with no backpressure. Sustained 64-bit input equals 64-bit output, so the accumulator never overflows (max 127 bits before emit, 128 only transiently in DRAIN).
- A flush that needs two words gives `out_valid` in T+1 (full word) and T+2 (residual).
- Reset values: `out_valid`=0, `out_data`=0, `out_num_bytes`=0, `total_byte_size`=0, `fill_bits`=0, `size_err`=0, `acc`=0, state RUN.
- Reset asserted mid-stream or in DRAIN discards all pending bits; the inputs in that cycle are ignored.
- `fill_bits` reflects the post-cycle fill, updated with `out_valid`.

## Test plan
- Eight cycles of `val`=0x12, size 8 -> one cycle after the 8th: `out_valid`=1, `out_data`=0x1212121212121212, `out_num_bytes`=8, `total_byte_size`=8.
- `val`=0x5 size 3, next cycle `flush` -> `out_data`=0xA000000000000000, `out_num_bytes`=1, `total_byte_size`=1, `fill_bits`=0.
- `val`=0x0FFFFFFFFFFFFFFF size 60, then `val`=0x00 size 8 with `flush` -> first cycle `out_data`=0xFFFFFFFFFFFFFFF0 (8 bytes); next cycle `out_data`=0x0000000000000000, 1 byte; total 9.
- `val`=all ones, size 65 -> `size_err` pulse, no `out_valid`, `fill_bits` unchanged; then size 0 -> no-op.
- During DRAIN, `val`=0xAB size 8 with `flush` -> residual word emitted, then 0xAB00000000000000 with 1 byte, then return to RUN.
- Append 40 bits then assert `reset` -> all outputs 0; a following 8-bit append plus flush yields a 1-byte word containing only the new bits.

Source files
------------

// File: rtl/bit_packer_if.sv
// Set-bit request bus from the header generator / slice coders and the packed
// 64-bit word output toward the buffer writer.
interface bit_packer_if #(
  parameter int unsigned BYTE_COUNT_WIDTH = 32
);
  logic                        enable;
  logic [63:0]                 val;
  logic [63:0]                 size_of_bit;
  logic                        flush;
  logic                        out_valid;
  logic [63:0]                 out_data;
  logic [3:0]                  out_num_bytes;
  logic [BYTE_COUNT_WIDTH-1:0] total_byte_size;
  logic [6:0]                  fill_bits;
  logic                        size_err;

  modport master (
    output enable, val, size_of_bit, flush,
    input  out_valid, out_data, out_num_bytes, total_byte_size, fill_bits, size_err
  );

  modport slave (
    input  enable, val, size_of_bit, flush,
    output out_valid, out_data, out_num_bytes, total_byte_size, fill_bits, size_err
  );
endinterface

// File: rtl/bit_packer.sv
// Packs variable-length MSB-first bit fields into a continuous stream and
// emits it as big-endian 64-bit words with a running byte count.
module bit_packer #(
  parameter int unsigned BYTE_COUNT_WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  bit_packer_if.slave  bus
);
  localparam int unsigned ACC_W  = 128;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned FILL_W = 8;

  typedef enum logic [0:0] {ST_RUN, ST_DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic                        out_valid_q, out_valid_d;
  logic [WORD_W-1:0]           out_data_q, out_data_d;
  logic [3:0]                  out_num_bytes_q, out_num_bytes_d;
  logic [BYTE_COUNT_WIDTH-1:0] total_q, total_d;
  logic                        size_err_q, size_err_d;

  logic                        app_en;
  logic [FILL_W-1:0]           n_bits;
  logic [WORD_W-1:0]           val_masked;
  logic [FILL_W-1:0]           app_shamt;
  logic [ACC_W-1:0]            sum_acc;
  logic [FILL_W-1:0]           sum_fill;
  logic [FILL_W-1:0]           pad_fill;
  logic [FILL_W-1:0]           pad_new;
  logic [WORD_W-1:0]           keep_mask;

  // Append stage: new field lands directly below the bits already held.
  always_comb begin
    app_en     = bus.enable && (bus.size_of_bit != 64'd0) && (bus.size_of_bit <= 64'd64);
    n_bits     = app_en ? FILL_W'(bus.size_of_bit) : FILL_W'(0);
    val_masked = app_en ? (bus.val & ({WORD_W{1'b1}} >> (FILL_W'(64) - n_bits))) : WORD_W'(0);
    app_shamt  = FILL_W'(128) - fill_q - n_bits;
    sum_acc    = acc_q | ({{(ACC_W-WORD_W){1'b0}}, val_masked} << app_shamt);
    sum_fill   = fill_q + n_bits;
    pad_fill   = (sum_fill + FILL_W'(7)) & FILL_W'(8'hF8);
    pad_new    = (n_bits + FILL_W'(7)) & FILL_W'(8'hF8);
  end

  // Next-state and emit decision.
  always_comb begin
    state_d         = state_q;
    acc_d           = sum_acc;
    fill_d          = sum_fill;
    out_valid_d     = 1'b0;
    out_num_bytes_d = 4'd0;
    size_err_d      = bus.enable && (bus.size_of_bit > 64'd64);
    keep_mask       = '0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          if (pad_fill == FILL_W'(0)) begin
            fill_d = FILL_W'(0);
          end else if (pad_fill <= FILL_W'(64)) begin
            out_valid_d     = 1'b1;
            out_num_bytes_d = 4'(pad_fill >> 3);
            acc_d           = '0;
            fill_d          = FILL_W'(0);
          end else begin
            out_valid_d     = 1'b1;
            out_num_bytes_d = 4'd8;
            acc_d           = sum_acc << WORD_W;
            fill_d          = pad_fill - FILL_W'(64);
            state_d         = ST_DRAIN;
          end
        end else if (sum_fill >= FILL_W'(64)) begin
          out_valid_d     = 1'b1;
          out_num_bytes_d = 4'd8;
          acc_d           = sum_acc << WORD_W;
          fill_d          = sum_fill - FILL_W'(64);
        end
      end
      ST_DRAIN: begin
        // Residual is byte-aligned; bits appended this cycle sit behind it.
        out_valid_d     = 1'b1;
        out_num_bytes_d = 4'(fill_q >> 3);
        acc_d           = sum_acc << fill_q;
        fill_d          = n_bits;
        if (bus.flush && app_en) begin
          fill_d = pad_new;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    keep_mask  = ~({WORD_W{1'b1}} >> {out_num_bytes_d, 3'b000});
    out_data_d = out_valid_d ? (sum_acc[ACC_W-1 -: WORD_W] & keep_mask) : WORD_W'(0);
    total_d    = total_q + BYTE_COUNT_WIDTH'(out_num_bytes_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_RUN;
      acc_q           <= '0;
      fill_q          <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_num_bytes_q <= '0;
      total_q         <= '0;
      size_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      fill_q          <= fill_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_num_bytes_q <= out_num_bytes_d;
      total_q         <= total_d;
      size_err_q      <= size_err_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_num_bytes   = out_num_bytes_q;
  assign bus.total_byte_size = total_q;
  assign bus.fill_bits       = 7'(fill_q);
  assign bus.size_err        = size_err_q;
endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: directed scenarios plus randomized
// traffic against a bit-queue reference model.
module tb_bit_packer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit_packer_if #(.BYTE_COUNT_WIDTH(32)) bus ();
  bit_packer #(.BYTE_COUNT_WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Reference model: pending stream bits plus the size of a residual awaiting drain.
  bit          mq[$];
  int          resid = 0;
  logic        e_ov;
  logic [3:0]  e_nb;
  logic [63:0] e_data;
  logic [31:0] e_tot;
  logic        e_err;

  task automatic model_clear();
    mq.delete();
    resid = 0;
    e_ov = 0; e_nb = 0; e_data = 0; e_tot = 0; e_err = 0;
  endtask

  task automatic model_emit(input int k);
    e_ov = 1'b1;
    e_nb = 4'(k / 8);
    for (int i = 0; i < k; i++) e_data[63-i] = mq.pop_front();
  endtask

  task automatic model_pad();
    while ((mq.size() % 8) != 0) mq.push_back(1'b0);
  endtask

  task automatic model_step(input logic en, input logic [63:0] v, input logic [63:0] sz,
                            input logic fl);
    bit app;
    int n;
    app    = en && (sz >= 64'd1) && (sz <= 64'd64);
    n      = app ? int'(sz) : 0;
    e_ov   = 0; e_nb = 0; e_data = 0;
    e_err  = en && (sz > 64'd64);
    for (int i = n - 1; i >= 0; i--) mq.push_back(v[i]);
    if (resid > 0) begin
      model_emit(resid);
      if (fl && app) begin
        model_pad();
        resid = mq.size();
      end else begin
        resid = 0;
      end
    end else if (fl) begin
      model_pad();
      if (mq.size() > 64) begin
        model_emit(64);
        resid = mq.size();
      end else if (mq.size() > 0) begin
        model_emit(mq.size());
      end
    end else if (mq.size() >= 64) begin
      model_emit(64);
    end
    e_tot = e_tot + 32'(e_nb);
  endtask

  task automatic step(input logic en, input logic [63:0] v, input logic [63:0] sz,
                      input logic fl);
    bus.enable = en; bus.val = v; bus.size_of_bit = sz; bus.flush = fl;
    @(posedge clock);
    #1;
    model_step(en, v, sz, fl);
    bus.enable = 1'b0; bus.flush = 1'b0; bus.size_of_bit = '0; bus.val = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b1; bus.val = {$urandom, $urandom}; bus.size_of_bit = 64'd8; bus.flush = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.enable = 1'b0; bus.flush = 1'b0; bus.size_of_bit = '0; bus.val = '0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size, bus.fill_bits,
         bus.size_err} !== 110'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b data=%h nb=%0d tot=%0d fill=%0d err=%0b, want all 0",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size,
               bus.fill_bits, bus.size_err);
    end
  endtask

  task automatic test_full_word();
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 64'h12, 64'd8, 0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fill_bits !== 7'd56) begin
      errors++;
      $display("FAIL full_word_pre: valid=%0b fill=%0d, want 0/56", bus.out_valid, bus.fill_bits);
    end
    step(1, 64'h12, 64'd8, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h1212121212121212 ||
        bus.out_num_bytes !== 4'd8 || bus.total_byte_size !== 32'd8 || bus.fill_bits !== 7'd0) begin
      errors++;
      $display("FAIL full_word: valid=%0b data=%h nb=%0d tot=%0d fill=%0d, want 1/1212121212121212/8/8/0",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size, bus.fill_bits);
    end
  endtask

  task automatic test_flush_partial();
    do_reset();
    step(1, 64'h5, 64'd3, 0);
    step(0, 64'h0, 64'd0, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA000000000000000 ||
        bus.out_num_bytes !== 4'd1 || bus.total_byte_size !== 32'd1 || bus.fill_bits !== 7'd0) begin
      errors++;
      $display("FAIL flush_partial: valid=%0b data=%h nb=%0d tot=%0d fill=%0d, want 1/a000000000000000/1/1/0",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size, bus.fill_bits);
    end
  endtask

  task automatic test_two_word_flush();
    do_reset();
    step(1, 64'h0FFFFFFFFFFFFFFF, 64'd60, 0);
    step(1, 64'h0, 64'd8, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hFFFFFFFFFFFFFFF0 || bus.out_num_bytes !== 4'd8) begin
      errors++;
      $display("FAIL two_word_first: valid=%0b data=%h nb=%0d, want 1/fffffffffffffff0/8",
               bus.out_valid, bus.out_data, bus.out_num_bytes);
    end
    step(0, 64'h0, 64'd0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0 || bus.out_num_bytes !== 4'd1 ||
        bus.total_byte_size !== 32'd9 || bus.fill_bits !== 7'd0) begin
      errors++;
      $display("FAIL two_word_second: valid=%0b data=%h nb=%0d tot=%0d fill=%0d, want 1/0/1/9/0",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size, bus.fill_bits);
    end
  endtask

  task automatic test_size_err();
    do_reset();
    step(1, 64'h1F, 64'd5, 0);
    step(1, 64'hFFFFFFFFFFFFFFFF, 64'd65, 0);
    checks++;
    if (bus.size_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.fill_bits !== 7'd5) begin
      errors++;
      $display("FAIL size_err_pulse: err=%0b valid=%0b fill=%0d, want 1/0/5",
               bus.size_err, bus.out_valid, bus.fill_bits);
    end
    step(1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 0);
    checks++;
    if (bus.size_err !== 1'b0 || bus.out_valid !== 1'b0 || bus.fill_bits !== 7'd5) begin
      errors++;
      $display("FAIL size_zero_noop: err=%0b valid=%0b fill=%0d, want 0/0/5",
               bus.size_err, bus.out_valid, bus.fill_bits);
    end
    step(0, 64'h0, 64'd0, 1);
    checks++;
    if (bus.out_data !== 64'hF800000000000000 || bus.out_num_bytes !== 4'd1) begin
      errors++;
      $display("FAIL size_err_stream: data=%h nb=%0d, want f800000000000000/1",
               bus.out_data, bus.out_num_bytes);
    end
  endtask

  task automatic test_drain_append();
    do_reset();
    step(1, 64'h0FFFFFFFFFFFFFFF, 64'd60, 0);
    step(1, 64'h0, 64'd8, 1);
    step(1, 64'hFFFFFFFFFFFFFFAB, 64'd8, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0 || bus.out_num_bytes !== 4'd1 ||
        bus.total_byte_size !== 32'd9) begin
      errors++;
      $display("FAIL drain_residual: valid=%0b data=%h nb=%0d tot=%0d, want 1/0/1/9",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size);
    end
    step(0, 64'h0, 64'd0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hAB00000000000000 ||
        bus.out_num_bytes !== 4'd1 || bus.total_byte_size !== 32'd10 || bus.fill_bits !== 7'd0) begin
      errors++;
      $display("FAIL drain_append: valid=%0b data=%h nb=%0d tot=%0d fill=%0d, want 1/ab00000000000000/1/10/0",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size, bus.fill_bits);
    end
    step(1, 64'h77, 64'd8, 0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fill_bits !== 7'd8 || bus.total_byte_size !== 32'd10) begin
      errors++;
      $display("FAIL drain_back_to_run: valid=%0b fill=%0d tot=%0d, want 0/8/10",
               bus.out_valid, bus.fill_bits, bus.total_byte_size);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 64'hFFFFFFFFFF, 64'd40, 0);
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fill_bits !== 7'd0 || bus.total_byte_size !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b fill=%0d tot=%0d, want 0/0/0",
               bus.out_valid, bus.fill_bits, bus.total_byte_size);
    end
    step(1, 64'h3C, 64'd8, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h3C00000000000000 ||
        bus.out_num_bytes !== 4'd1 || bus.total_byte_size !== 32'd1) begin
      errors++;
      $display("FAIL reset_mid_after: valid=%0b data=%h nb=%0d tot=%0d, want 1/3c00000000000000/1/1",
               bus.out_valid, bus.out_data, bus.out_num_bytes, bus.total_byte_size);
    end
  endtask

  task automatic test_back_to_back();
    logic [109:0] got, want;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step(1, {$urandom, $urandom}, 64'd64 - 64'(c % 3), (c % 13) == 12);
      got  = {bus.out_valid, bus.out_num_bytes, bus.out_data, bus.total_byte_size,
              bus.fill_bits, bus.size_err};
      want = {e_ov, e_nb, e_data, e_tot, 7'(mq.size()), e_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_random();
    logic [109:0] got, want;
    logic [63:0]  sz;
    int           sel;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        sel = int'($urandom_range(0, 99));
        if (sel < 8)       sz = 64'd0;
        else if (sel < 14) sz = 64'd65 + 64'($urandom_range(0, 1000));
        else if (sel < 16) sz = {$urandom, $urandom} | 64'h8000000000000000;
        else if (sel < 30) sz = 64'd64;
        else               sz = 64'($urandom_range(1, 64));
        step($urandom_range(0, 9) != 0, {$urandom, $urandom}, sz, $urandom_range(0, 9) == 0);
      end
      got  = {bus.out_valid, bus.out_num_bytes, bus.out_data, bus.total_byte_size,
              bus.fill_bits, bus.size_err};
      want = {e_ov, e_nb, e_data, e_tot, 7'(mq.size()), e_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", c, got, want);
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0; bus.val = '0; bus.size_of_bit = '0; bus.flush = 1'b0;
    model_clear();
    test_reset();
    test_full_word();
    test_flush_partial();
    test_two_word_flush();
    test_size_err();
    test_drain_append();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
